exe_load_resp_formatter: RTL and testbench
==========================================

# exe_load_resp_formatter

Data-cache response stage between the execute load/store unit and writeback. Records metadata for each accepted load/AMO request and matches the returning data-cache response by tag. Extracts and sign/zero-extends the addressed byte/half/word/dword, then presents the result to writeback through a 2-entry valid/ready buffer. Also reports NACK/replay so the upstream unit can reissue, and flushes on pipeline kill.

## Interface
- DATA_W, 64, data width
- TAG_W, 8, request/response tag width
- DEPTH, 2, writeback buffer entries
- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous reset, active-high
- REQ_FIRE  in  1  request accepted by data cache this cycle (MEM_REQ_VALID & DMEM_REQ_READY)
- REQ_IS_LOAD  in  1  request returns data (load or AMO); stores ignored
- REQ_OP_TYPE  in  4  {0,funct3}: [1:0] size (0 B, 1 H, 2 W, 3 D), [2] unsigned
- REQ_ADDR_LSB  in  3  request address bits [2:0]
- REQ_TAG  in  TAG_W  request tag; rd = REQ_TAG[5:1]
- KILL  in  1  WB exception or ERET
- RESP_VALID  in  1  cache response valid
- RESP_TAG  in  TAG_W  response tag
- RESP_DATA  in  DATA_W  raw 64-bit aligned doubleword
- RESP_NACK  in  1  cache NACK
- RESP_REPLAY  in  1  cache replay, treated as NACK
- REQ_READY  out  1  upstream may fire a load
- NACK_PULSE  out  1  one-cycle pulse: pending request must be reissued
- WB_VALID  out  1  formatted result available
- WB_READY  in  1  writeback accepts
- WB_DATA  out  DATA_W  formatted result
- WB_RD  out  5  destination register
- BUSY  out  1  pending request or buffer non-empty
- PROTO_ERR  out  1  sticky: fire while pending, or tag mismatch

## Operation
- FSM states IDLE and WAIT_RESP. Reset/KILL go to IDLE.
- REQ_READY = IDLE & (count < DEPTH). This reserves a buffer slot for every pending load.
- IDLE: REQ_FIRE & REQ_IS_LOAD & ~KILL captures op, lsb, and tag, then goes to WAIT_RESP.
  - Store fires are not captured.
  - RESP_VALID in IDLE is ignored (store ack or killed response), with no error.
- WAIT_RESP outcomes:
  - RESP_VALID with tag equal: push the formatted result, go to IDLE.
  - RESP_VALID with tag different: drop it, set PROTO_ERR, stay in WAIT_RESP.
  - RESP_NACK | RESP_REPLAY: NACK_PULSE=1 next cycle, go to IDLE.
  - REQ_FIRE: ignored, sets PROTO_ERR.
- Priority: KILL > RESP_VALID > NACK/REPLAY.
- KILL clears the pending entry and all buffer entries, with no WB_VALID the next cycle. KILL does not clear PROTO_ERR.
- Formatting:
  - shift = lsb aligned to size: B uses [2:0], H uses [2:1], W uses [2], D uses 0.
  - data >> (shift*8), then truncate to size, sign-extend if [2]=0, otherwise zero-extend.
  - Misalignment is not checked (the cache raises it).
- Buffer is a FIFO of DEPTH entries {data, rd}.
  - Pop on WB_VALID & WB_READY.
  - Push and pop in the same cycle keeps count. Wrap-around uses pointer modulo DEPTH.

## Timing
- Response to WB_VALID latency is 1 cycle: result registered into the buffer at the RESP_VALID edge.
- WB_VALID holds, and WB_DATA/WB_RD stay stable, until accepted.
- NACK to NACK_PULSE latency is 1 cycle. REQ_READY returns high the same cycle as NACK_PULSE.
- Reset values: REQ_READY=1, NACK_PULSE=0, WB_VALID=0, WB_DATA=0, WB_RD=0, BUSY=0, PROTO_ERR=0. FSM=IDLE, count=0.
- RST mid-operation: drops pending and buffered entries immediately; a response arriving during or after reset is ignored.
- Full buffer (count=DEPTH): REQ_READY=0. A matching response still pushes, since the slot was reserved.

## Structure
- Package exe_mem_pkg holds:
  - size enum (SZ_B/H/W/D)
  - FSM state enum
  - DEPTH default, TAG_W
  - rd-from-tag field positions
- Sub-module load_data_align: purely combinational. Inputs are raw data, op type, and lsb; output is the formatted 64-bit value.
- FIFO and FSM stay in the top module.

## Test plan
- LB at lsb=5, RESP_DATA=0x0000_8000_0000_0000 (byte5=0x80) -> WB_DATA=0xFFFF_FFFF_FFFF_FF80, WB_RD=tag[5:1], 1 cycle after the response.
- LHU at lsb=6, data=0xBEEF_0000_0000_0000 -> WB_DATA=0x0000_0000_0000_BEEF.
- LW at lsb=4 then LD, with WB_READY=0 -> after the two responses, count=2 and REQ_READY=0. Raise WB_READY -> the two results pop in order (sign-extended word, then the full dword).
- Load fired, then RESP_NACK -> NACK_PULSE for one cycle, FSM in IDLE, no WB_VALID. Reissue and match -> normal writeback.
- Load pending, with KILL and matching RESP_VALID in the same cycle -> nothing pushed, WB_VALID stays 0, REQ_READY=1 next cycle.
- Pending tag 0x0A, RESP_VALID with tag 0x0C -> dropped, PROTO_ERR=1 sticky, still WAIT_RESP. Then tag 0x0A -> written back.

Source files
------------

// File: rtl/exe_mem_pkg.sv
// Shared types and field positions for the execute-stage load response path.
package exe_mem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_RESP = 1'b1
    } state_e;

    localparam int unsigned DEPTH_DEF = 2;
    localparam int unsigned TAG_W_DEF = 8;

    // Destination register is carried in the request tag.
    localparam int unsigned RD_LSB = 1;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned RD_MSB = RD_LSB + RD_W - 1;

endpackage

// File: rtl/load_data_align.sv
// Selects the addressed byte/half/word/dword from an aligned doubleword and extends it.
module load_data_align
    import exe_mem_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] raw_data_i,
    input  logic [2:0]        op_i,
    input  logic [2:0]        lsb_i,
    output logic [DATA_W-1:0] data_o
);

    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v,
                                                 input size_e sz,
                                                 input logic uns);
        logic [DATA_W-1:0] r;
        case (sz)
            SZ_B:    r = uns ? {{(DATA_W-8){1'b0}}, v[7:0]}   : {{(DATA_W-8){v[7]}}, v[7:0]};
            SZ_H:    r = uns ? {{(DATA_W-16){1'b0}}, v[15:0]} : {{(DATA_W-16){v[15]}}, v[15:0]};
            SZ_W:    r = uns ? {{(DATA_W-32){1'b0}}, v[31:0]} : {{(DATA_W-32){v[31]}}, v[31:0]};
            default: r = v;
        endcase
        return r;
    endfunction

    size_e             sz;
    logic [2:0]        byte_off;
    logic [5:0]        shamt;
    logic [DATA_W-1:0] shifted;

    always_comb begin
        sz = size_e'(op_i[1:0]);
        // Low address bits below the access size are ignored rather than flagged.
        case (sz)
            SZ_B:    byte_off = lsb_i;
            SZ_H:    byte_off = {lsb_i[2:1], 1'b0};
            SZ_W:    byte_off = {lsb_i[2], 2'b00};
            default: byte_off = 3'b000;
        endcase
        shamt   = {byte_off, 3'b000};
        shifted = raw_data_i >> shamt;
        data_o  = extend(shifted, sz, op_i[2]);
    end

endmodule

// File: rtl/exe_load_resp_formatter.sv
// Tracks one outstanding load, matches its cache response by tag, and queues the formatted result for writeback.
module exe_load_resp_formatter
    import exe_mem_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int TAG_W  = TAG_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_FIRE,
    input  logic              REQ_IS_LOAD,
    input  logic [3:0]        REQ_OP_TYPE,
    input  logic [2:0]        REQ_ADDR_LSB,
    input  logic [TAG_W-1:0]  REQ_TAG,
    input  logic              KILL,
    input  logic              RESP_VALID,
    input  logic [TAG_W-1:0]  RESP_TAG,
    input  logic [DATA_W-1:0] RESP_DATA,
    input  logic              RESP_NACK,
    input  logic              RESP_REPLAY,
    output logic              REQ_READY,
    output logic              NACK_PULSE,
    output logic              WB_VALID,
    input  logic              WB_READY,
    output logic [DATA_W-1:0] WB_DATA,
    output logic [RD_W-1:0]   WB_RD,
    output logic              BUSY,
    output logic              PROTO_ERR
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e             state_q, state_d;
    logic               nack_q, nack_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   count_q;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;

    logic [2:0]         op_q;
    logic [2:0]         lsb_q;
    logic [TAG_W-1:0]   tag_q;

    logic [DATA_W-1:0]  data_mem_q [DEPTH];
    logic [RD_W-1:0]    rd_mem_q   [DEPTH];

    logic               capture, push, push_en, pop, full;
    logic [DATA_W-1:0]  aligned;
    logic               op_unused;

    assign op_unused = REQ_OP_TYPE[3];

    load_data_align #(.DATA_W(DATA_W)) u_align (
        .raw_data_i (RESP_DATA),
        .op_i       (op_q),
        .lsb_i      (lsb_q),
        .data_o     (aligned)
    );

    assign full       = (count_q == CNT_W'(DEPTH));
    assign REQ_READY  = (state_q == ST_IDLE) && !full;
    assign NACK_PULSE = nack_q;
    assign WB_VALID   = (count_q != '0);
    assign WB_DATA    = WB_VALID ? data_mem_q[rd_ptr_q] : '0;
    assign WB_RD      = WB_VALID ? rd_mem_q[rd_ptr_q] : '0;
    assign BUSY       = (state_q == ST_WAIT_RESP) || WB_VALID;
    assign PROTO_ERR  = err_q;

    always_comb begin
        state_d = state_q;
        nack_d  = 1'b0;
        err_d   = err_q;
        capture = 1'b0;
        push    = 1'b0;
        if (KILL) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (REQ_FIRE && REQ_IS_LOAD) begin
                        capture = 1'b1;
                        state_d = ST_WAIT_RESP;
                    end
                end
                ST_WAIT_RESP: begin
                    if (RESP_VALID) begin
                        if (RESP_TAG == tag_q) begin
                            push    = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (RESP_NACK || RESP_REPLAY) begin
                        nack_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if ((state_q == ST_WAIT_RESP) && REQ_FIRE) begin
            err_d = 1'b1;
        end
    end

    assign pop     = WB_VALID && WB_READY && !KILL;
    // The slot is reserved at issue; the guard only protects against an upstream that ignores REQ_READY.
    assign push_en = push && (!full || pop);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            nack_q   <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            nack_q  <= nack_d;
            err_q   <= err_d;
            if (KILL) begin
                count_q  <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push_en) begin
                    wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
                end
                case ({push_en, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (capture) begin
            op_q  <= REQ_OP_TYPE[2:0];
            lsb_q <= REQ_ADDR_LSB;
            tag_q <= REQ_TAG;
        end
        if (push_en) begin
            data_mem_q[wr_ptr_q] <= aligned;
            rd_mem_q[wr_ptr_q]   <= tag_q[RD_MSB:RD_LSB];
        end
    end

endmodule

// File: tb/tb_exe_load_resp_formatter.sv
// Directed bench for the load response formatter: formatting, buffering, NACK, KILL, tag mismatch and reset.
module tb_exe_load_resp_formatter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        REQ_FIRE, REQ_IS_LOAD;
    logic [3:0]  REQ_OP_TYPE;
    logic [2:0]  REQ_ADDR_LSB;
    logic [7:0]  REQ_TAG;
    logic        KILL;
    logic        RESP_VALID;
    logic [7:0]  RESP_TAG;
    logic [63:0] RESP_DATA;
    logic        RESP_NACK, RESP_REPLAY;
    logic        REQ_READY, NACK_PULSE, WB_VALID, WB_READY;
    logic [63:0] WB_DATA;
    logic [4:0]  WB_RD;
    logic        BUSY, PROTO_ERR;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    exe_load_resp_formatter #(.DATA_W(64), .TAG_W(8), .DEPTH(2)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_FIRE(REQ_FIRE), .REQ_IS_LOAD(REQ_IS_LOAD), .REQ_OP_TYPE(REQ_OP_TYPE),
        .REQ_ADDR_LSB(REQ_ADDR_LSB), .REQ_TAG(REQ_TAG), .KILL(KILL),
        .RESP_VALID(RESP_VALID), .RESP_TAG(RESP_TAG), .RESP_DATA(RESP_DATA),
        .RESP_NACK(RESP_NACK), .RESP_REPLAY(RESP_REPLAY),
        .REQ_READY(REQ_READY), .NACK_PULSE(NACK_PULSE), .WB_VALID(WB_VALID),
        .WB_READY(WB_READY), .WB_DATA(WB_DATA), .WB_RD(WB_RD),
        .BUSY(BUSY), .PROTO_ERR(PROTO_ERR)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic fire_load(input logic [3:0] op, input logic [2:0] lsb, input logic [7:0] tag);
        REQ_FIRE = 1'b1; REQ_IS_LOAD = 1'b1; REQ_OP_TYPE = op; REQ_ADDR_LSB = lsb; REQ_TAG = tag;
        step();
        REQ_FIRE = 1'b0; REQ_IS_LOAD = 1'b0;
    endtask

    task automatic respond(input logic [7:0] tag, input logic [63:0] data);
        RESP_VALID = 1'b1; RESP_TAG = tag; RESP_DATA = data;
        step();
        RESP_VALID = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; REQ_FIRE = 0; REQ_IS_LOAD = 0; REQ_OP_TYPE = 0; REQ_ADDR_LSB = 0; REQ_TAG = 0;
        KILL = 0; RESP_VALID = 0; RESP_TAG = 0; RESP_DATA = 0; RESP_NACK = 0; RESP_REPLAY = 0;
        WB_READY = 0;
        step(); step();
        RST = 1'b0;
        step();
        checks++; if (REQ_READY !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", REQ_READY); end
        checks++; if (NACK_PULSE !== 1'b0) begin failures++; $display("FAIL reset_nack got=%b exp=0", NACK_PULSE); end
        checks++; if (WB_VALID !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%b exp=0", WB_VALID); end
        checks++; if (WB_DATA !== 64'h0) begin failures++; $display("FAIL reset_wb_data got=%h exp=0", WB_DATA); end
        checks++; if (WB_RD !== 5'd0) begin failures++; $display("FAIL reset_wb_rd got=%0d exp=0", WB_RD); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
        checks++; if (PROTO_ERR !== 1'b0) begin failures++; $display("FAIL reset_proto_err got=%b exp=0", PROTO_ERR); end
    endtask

    task automatic test_lb_sign();
        fire_load(4'b0000, 3'd5, 8'h06);
        checks++; if (REQ_READY !== 1'b0) begin failures++; $display("FAIL lb_pending_ready got=%b exp=0", REQ_READY); end
        checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL lb_pending_busy got=%b exp=1", BUSY); end
        respond(8'h06, 64'h0000_8000_0000_0000);
        checks++; if (WB_VALID !== 1'b1) begin failures++; $display("FAIL lb_wb_valid got=%b exp=1", WB_VALID); end
        checks++; if (WB_DATA !== 64'hFFFF_FFFF_FFFF_FF80) begin failures++; $display("FAIL lb_wb_data got=%h exp=ffffffffffffff80", WB_DATA); end
        checks++; if (WB_RD !== 5'd3) begin failures++; $display("FAIL lb_wb_rd got=%0d exp=3", WB_RD); end
        checks++; if (REQ_READY !== 1'b1) begin failures++; $display("FAIL lb_ready_after got=%b exp=1", REQ_READY); end
        step();
        checks++; if (WB_VALID !== 1'b1 || WB_DATA !== 64'hFFFF_FFFF_FFFF_FF80) begin failures++; $display("FAIL lb_hold got=%b/%h exp=1/ffffffffffffff80", WB_VALID, WB_DATA); end
        WB_READY = 1'b1;
        step();
        WB_READY = 1'b0;
        checks++; if (WB_VALID !== 1'b0) begin failures++; $display("FAIL lb_popped got=%b exp=0", WB_VALID); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL lb_idle_busy got=%b exp=0", BUSY); end
    endtask

    task automatic test_lhu();
        fire_load(4'b0101, 3'd6, 8'h10);
        respond(8'h10, 64'hBEEF_0000_0000_0000);
        checks++; if (WB_DATA !== 64'h0000_0000_0000_BEEF) begin failures++; $display("FAIL lhu_data got=%h exp=000000000000beef", WB_DATA); end
        checks++; if (WB_RD !== 5'd8) begin failures++; $display("FAIL lhu_rd got=%0d exp=8", WB_RD); end
        WB_READY = 1'b1; step(); WB_READY = 1'b0;
    endtask

    task automatic test_back_to_back();
        fire_load(4'b0010, 3'd4, 8'h22);
        respond(8'h22, 64'h8765_4321_0000_0000);
        checks++; if (REQ_READY !== 1'b1) begin failures++; $display("FAIL b2b_ready_one got=%b exp=1", REQ_READY); end
        fire_load(4'b0011, 3'd0, 8'h24);
        respond(8'h24, 64'h0123_4567_89AB_CDEF);
        checks++; if (REQ_READY !== 1'b0) begin failures++; $display("FAIL b2b_ready_full got=%b exp=0", REQ_READY); end
        checks++; if (WB_DATA !== 64'hFFFF_FFFF_8765_4321 || WB_RD !== 5'd17) begin failures++; $display("FAIL b2b_first got=%h/%0d exp=ffffffff87654321/17", WB_DATA, WB_RD); end
        WB_READY = 1'b1;
        step();
        checks++; if (WB_VALID !== 1'b1 || WB_DATA !== 64'h0123_4567_89AB_CDEF || WB_RD !== 5'd18) begin failures++; $display("FAIL b2b_second got=%b/%h/%0d exp=1/0123456789abcdef/18", WB_VALID, WB_DATA, WB_RD); end
        checks++; if (REQ_READY !== 1'b1) begin failures++; $display("FAIL b2b_ready_freed got=%b exp=1", REQ_READY); end
        step();
        WB_READY = 1'b0;
        checks++; if (WB_VALID !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", WB_VALID); end
    endtask

    task automatic test_nack();
        fire_load(4'b0000, 3'd0, 8'h30);
        RESP_NACK = 1'b1; step(); RESP_NACK = 1'b0;
        checks++; if (NACK_PULSE !== 1'b1) begin failures++; $display("FAIL nack_pulse got=%b exp=1", NACK_PULSE); end
        checks++; if (REQ_READY !== 1'b1) begin failures++; $display("FAIL nack_ready got=%b exp=1", REQ_READY); end
        checks++; if (WB_VALID !== 1'b0) begin failures++; $display("FAIL nack_wb_valid got=%b exp=0", WB_VALID); end
        step();
        checks++; if (NACK_PULSE !== 1'b0) begin failures++; $display("FAIL nack_one_cycle got=%b exp=0", NACK_PULSE); end
        fire_load(4'b0100, 3'd0, 8'h30);
        respond(8'h30, 64'h1234_5678_9ABC_DEFF);
        checks++; if (WB_VALID !== 1'b1 || WB_DATA !== 64'h0000_0000_0000_00FF || WB_RD !== 5'd24) begin failures++; $display("FAIL nack_reissue got=%b/%h/%0d exp=1/00000000000000ff/24", WB_VALID, WB_DATA, WB_RD); end
        WB_READY = 1'b1; step(); WB_READY = 1'b0;
        fire_load(4'b0000, 3'd1, 8'h32);
        RESP_REPLAY = 1'b1; step(); RESP_REPLAY = 1'b0;
        checks++; if (NACK_PULSE !== 1'b1 || REQ_READY !== 1'b1) begin failures++; $display("FAIL replay_pulse got=%b/%b exp=1/1", NACK_PULSE, REQ_READY); end
        step();
    endtask

    task automatic test_kill();
        fire_load(4'b0011, 3'd0, 8'h40);
        KILL = 1'b1; RESP_VALID = 1'b1; RESP_TAG = 8'h40; RESP_DATA = 64'h5555_5555_5555_5555;
        step();
        KILL = 1'b0; RESP_VALID = 1'b0;
        checks++; if (WB_VALID !== 1'b0) begin failures++; $display("FAIL kill_resp_wb_valid got=%b exp=0", WB_VALID); end
        checks++; if (REQ_READY !== 1'b1 || BUSY !== 1'b0) begin failures++; $display("FAIL kill_resp_idle got=%b/%b exp=1/0", REQ_READY, BUSY); end
        fire_load(4'b0011, 3'd0, 8'h42);
        respond(8'h42, 64'h1111_2222_3333_4444);
        checks++; if (WB_VALID !== 1'b1) begin failures++; $display("FAIL kill_pre_flush got=%b exp=1", WB_VALID); end
        KILL = 1'b1; step(); KILL = 1'b0;
        checks++; if (WB_VALID !== 1'b0 || BUSY !== 1'b0) begin failures++; $display("FAIL kill_flush got=%b/%b exp=0/0", WB_VALID, BUSY); end
        checks++; if (PROTO_ERR !== 1'b0) begin failures++; $display("FAIL kill_no_err got=%b exp=0", PROTO_ERR); end
    endtask

    task automatic test_tag_mismatch();
        fire_load(4'b0110, 3'd0, 8'h0A);
        respond(8'h0C, 64'h9999_9999_9999_9999);
        checks++; if (PROTO_ERR !== 1'b1) begin failures++; $display("FAIL mism_err got=%b exp=1", PROTO_ERR); end
        checks++; if (WB_VALID !== 1'b0 || REQ_READY !== 1'b0 || BUSY !== 1'b1) begin failures++; $display("FAIL mism_waiting got=%b/%b/%b exp=0/0/1", WB_VALID, REQ_READY, BUSY); end
        respond(8'h0A, 64'hAAAA_BBBB_CCCC_DDDD);
        checks++; if (WB_VALID !== 1'b1 || WB_DATA !== 64'h0000_0000_CCCC_DDDD || WB_RD !== 5'd5) begin failures++; $display("FAIL mism_match got=%b/%h/%0d exp=1/00000000ccccdddd/5", WB_VALID, WB_DATA, WB_RD); end
        KILL = 1'b1; step(); KILL = 1'b0;
        checks++; if (PROTO_ERR !== 1'b1) begin failures++; $display("FAIL mism_sticky got=%b exp=1", PROTO_ERR); end
    endtask

    task automatic test_reset_mid();
        fire_load(4'b0011, 3'd0, 8'h50);
        RST = 1'b1; RESP_VALID = 1'b1; RESP_TAG = 8'h50; RESP_DATA = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        RST = 1'b0;
        step();
        RESP_VALID = 1'b0;
        checks++; if (WB_VALID !== 1'b0 || BUSY !== 1'b0 || REQ_READY !== 1'b1) begin failures++; $display("FAIL rst_mid got=%b/%b/%b exp=0/0/1", WB_VALID, BUSY, REQ_READY); end
        checks++; if (PROTO_ERR !== 1'b0) begin failures++; $display("FAIL rst_mid_err got=%b exp=0", PROTO_ERR); end
    endtask

    initial begin
        test_reset();
        test_lb_sign();
        test_lhu();
        test_back_to_back();
        test_nack();
        test_kill();
        test_tag_mismatch();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
